// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline.
// It gates the PC and pipeline-register enables, inserts load-use bubbles and flushes IF/ID
// on taken branches. It freezes the pipeline during multi-cycle memory accesses, drains and
// halts on an all-zero instruction, and keeps cycle/stall counters.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_DEPTH = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      id_instr_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             halted_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // +2 keeps the width at least one bit even for DRAIN_DEPTH of zero
    localparam int unsigned DrainW = $clog2(DRAIN_DEPTH + 2);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StMemWait = 3'd2,
        StDrain   = 3'd3,
        StHalted  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              cyc_inc;
    logic              stall_inc;
    logic              load_use;
    logic              mem_stall;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use  = ex_memread_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    // A request acked in the same cycle is a single-cycle access and needs no stall
    assign mem_stall = mem_req_i && !mem_ack_i;

    // Next-state, drain counter and Mealy outputs
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        halted_o      = 1'b0;
        cyc_inc       = 1'b0;
        stall_inc     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!start_i) begin
                    // Pause: hold everything, counters included
                    freeze_o = 1'b1;
                end else begin
                    cyc_inc = 1'b1;
                    if (mem_stall) begin
                        freeze_o  = 1'b1;
                        stall_inc = 1'b1;
                        state_d   = StMemWait;
                    end else if (load_use) begin
                        // A branch seen now is dropped; it re-resolves after the bubble
                        idex_bubble_o = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (id_branch_taken_i) begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else if (id_instr_i == 32'd0) begin
                        // Zero instruction flows on into ID/EX; fetch stops here
                        state_d = StDrain;
                        drain_d = DrainW'(DRAIN_DEPTH);
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end
                end
            end
            StMemWait: begin
                // Freeze also covers the ack cycle; advance resumes the cycle after
                freeze_o  = 1'b1;
                cyc_inc   = 1'b1;
                stall_inc = 1'b1;
                if (mem_ack_i) begin
                    state_d = StRun;
                end
            end
            StDrain: begin
                cyc_inc = 1'b1;
                if (mem_stall) begin
                    freeze_o = 1'b1;
                end else if (drain_q <= DrainW'(1)) begin
                    drain_d = '0;
                    state_d = StHalted;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StHalted: begin
                halted_o = 1'b1;
                freeze_o = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating performance counters
    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        if (cyc_inc && (cycle_q != {CNT_W{1'b1}})) begin
            cycle_d = cycle_q + CNT_W'(1);
        end
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            drain_q <= '0;
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    assign state_o     = state_q;
    assign cycle_cnt_o = cycle_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, hazards, branch priority, memory wait, drain/halt
// and asynchronous reset, with hand-computed expected values.
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] id_instr_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        id_branch_taken_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        freeze_o;
    logic        halted_o;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_ctrl #(
        .DRAIN_DEPTH(3),
        .CNT_W      (32)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .id_instr_i       (id_instr_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .ex_memread_i     (ex_memread_i),
        .ex_rd_i          (ex_rd_i),
        .id_branch_taken_i(id_branch_taken_i),
        .mem_req_i        (mem_req_i),
        .mem_ack_i        (mem_ack_i),
        .pc_write_o       (pc_write_o),
        .ifid_write_o     (ifid_write_o),
        .ifid_flush_o     (ifid_flush_o),
        .idex_bubble_o    (idex_bubble_o),
        .freeze_o         (freeze_o),
        .halted_o         (halted_o),
        .state_o          (state_o),
        .cycle_cnt_o      (cycle_cnt_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_en(input string tag, input logic [31:0] pc, input logic [31:0] fr,
                          input logic [31:0] bub, input logic [31:0] fl);
        check({tag, "_pc"},     32'(pc_write_o),    pc);
        check({tag, "_ifid"},   32'(ifid_write_o),  pc);
        check({tag, "_freeze"}, 32'(freeze_o),      fr);
        check({tag, "_bubble"}, 32'(idex_bubble_o), bub);
        check({tag, "_flush"},  32'(ifid_flush_o),  fl);
    endtask

    initial begin
        rst_i             = 1'b1;
        start_i           = 1'b0;
        id_instr_i        = 32'h0000_0013;
        id_rs1_i          = 5'd1;
        id_rs2_i          = 5'd2;
        ex_memread_i      = 1'b0;
        ex_rd_i           = 5'd0;
        id_branch_taken_i = 1'b0;
        mem_req_i         = 1'b0;
        mem_ack_i         = 1'b0;

        // Reset held for two cycles
        cyc(); #1;
        check("rst_state", 32'(state_o), 0);
        chk_en("rst", 0, 0, 0, 0);
        check("rst_halted", 32'(halted_o), 0);
        check("rst_cycle", cycle_cnt_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        cyc(); #1;
        rst_i   = 1'b0;
        start_i = 1'b1;
        #1;
        check("idle_state", 32'(state_o), 0);
        chk_en("idle", 0, 0, 0, 0);

        // First RUN cycle
        cyc(); #1;
        check("run_state", 32'(state_o), 1);
        chk_en("run", 1, 0, 0, 0);
        check("run_cycle", cycle_cnt_o, 0);

        // Load-use on rs2
        cyc();
        ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5;
        #1;
        chk_en("lu", 0, 0, 1, 0);
        check("lu_cycle", cycle_cnt_o, 1);
        check("lu_stall0", stall_cnt_o, 0);
        cyc();
        ex_memread_i = 1'b0;
        #1;
        chk_en("lu_clr", 1, 0, 0, 0);
        check("lu_stall1", stall_cnt_o, 1);
        check("lu_cycle2", cycle_cnt_o, 2);

        // Load to x0 matching x0 sources: no hazard
        cyc();
        ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        #1;
        chk_en("x0", 1, 0, 0, 0);

        // Hazard beats branch
        cyc();
        ex_rd_i = 5'd5; id_rs1_i = 5'd1; id_rs2_i = 5'd5; id_branch_taken_i = 1'b1;
        #1;
        chk_en("brhz", 0, 0, 1, 0);
        check("brhz_stall", stall_cnt_o, 1);
        check("brhz_cycle", cycle_cnt_o, 4);
        cyc();
        ex_memread_i = 1'b0;
        #1;
        chk_en("br", 1, 0, 0, 1);
        check("br_stall", stall_cnt_o, 2);

        // Multi-cycle memory access: 3 waiting cycles then ack
        cyc();
        id_branch_taken_i = 1'b0; mem_req_i = 1'b1; mem_ack_i = 1'b0;
        #1;
        chk_en("mreq", 0, 1, 0, 0);
        check("mreq_state", 32'(state_o), 1);
        check("mreq_cycle", cycle_cnt_o, 6);
        cyc();
        mem_req_i = 1'b0;
        #1;
        check("mw1_state", 32'(state_o), 2);
        chk_en("mw1", 0, 1, 0, 0);
        check("mw1_stall", stall_cnt_o, 3);
        cyc(); #1;
        check("mw2_state", 32'(state_o), 2);
        check("mw2_freeze", 32'(freeze_o), 1);
        cyc();
        mem_ack_i = 1'b1;
        #1;
        check("mack_state", 32'(state_o), 2);
        check("mack_freeze", 32'(freeze_o), 1);
        cyc();
        mem_ack_i = 1'b0;
        #1;
        check("mdone_state", 32'(state_o), 1);
        chk_en("mdone", 1, 0, 0, 0);
        check("mdone_stall", stall_cnt_o, 6);
        check("mdone_cycle", cycle_cnt_o, 10);

        // Single-cycle access: no stall
        cyc();
        mem_req_i = 1'b1; mem_ack_i = 1'b1;
        #1;
        chk_en("m1c", 1, 0, 0, 0);

        // Pause with start_i low
        cyc();
        mem_req_i = 1'b0; mem_ack_i = 1'b0; start_i = 1'b0;
        #1;
        check("m1c_stall", stall_cnt_o, 6);
        check("pause_state", 32'(state_o), 1);
        chk_en("pause", 0, 1, 0, 0);
        check("pause_cycle", cycle_cnt_o, 12);
        cyc();
        start_i = 1'b1;
        #1;
        check("resume_state", 32'(state_o), 1);
        check("resume_cycle", cycle_cnt_o, 12);
        check("resume_pc", 32'(pc_write_o), 1);

        // Zero instruction: drain, with one memory hold, then halt
        cyc();
        id_instr_i = 32'd0;
        #1;
        chk_en("zero", 0, 0, 0, 0);
        check("zero_state", 32'(state_o), 1);
        cyc();
        id_instr_i = 32'h0000_0013;
        #1;
        check("dr1_state", 32'(state_o), 3);
        chk_en("dr1", 0, 0, 0, 0);
        cyc();
        mem_req_i = 1'b1;
        #1;
        check("dr2_state", 32'(state_o), 3);
        check("dr2_freeze", 32'(freeze_o), 1);
        cyc();
        mem_req_i = 1'b0;
        #1;
        check("dr3_state", 32'(state_o), 3);
        check("dr3_freeze", 32'(freeze_o), 0);
        cyc(); #1;
        check("dr4_state", 32'(state_o), 3);
        check("dr4_halted", 32'(halted_o), 0);
        cyc();
        start_i = 1'b0;
        #1;
        check("halt_state", 32'(state_o), 4);
        check("halt_halted", 32'(halted_o), 1);
        chk_en("halt", 0, 1, 0, 0);
        check("halt_cycle", cycle_cnt_o, 18);
        check("halt_stall", stall_cnt_o, 6);
        cyc();
        start_i = 1'b1;
        #1;
        check("halt2_state", 32'(state_o), 4);
        cyc(); #1;
        check("halt3_cycle", cycle_cnt_o, 18);
        check("halt3_halted", 32'(halted_o), 1);

        // Asynchronous reset while halted, then again while in MEM_WAIT
        rst_i = 1'b1;
        #1;
        check("ar_halt_state", 32'(state_o), 0);
        check("ar_halt_halted", 32'(halted_o), 0);
        rst_i = 1'b0;
        cyc();
        mem_req_i = 1'b1;
        #1;
        check("ar_run_state", 32'(state_o), 1);
        cyc();
        mem_req_i = 1'b0;
        #1;
        check("ar_mw_state", 32'(state_o), 2);
        check("ar_mw_cycle", cycle_cnt_o, 1);
        check("ar_mw_stall", stall_cnt_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("ar_state", 32'(state_o), 0);
        check("ar_freeze", 32'(freeze_o), 0);
        check("ar_cycle", cycle_cnt_o, 0);
        check("ar_stall", stall_cnt_o, 0);
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
